// File: rtl/cnn_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_chk_pkg
// Description : Shared types and helpers for the cnn_top sweep checker.
//               Holds the sequencer state encoding and the saturating
//               increment used by every statistics counter.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_chk_pkg;

    // Sequencer states, encoded explicitly in three bits
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRIVE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_GAP   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Increment that sticks at max_value instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_exp_rom.sv
`default_nettype none
// ============================================================================
// Module      : cnn_exp_rom
// Description : Expected-character table, one ALPHA_BW entry per image
//               index. Synchronous read: data appears one cycle after the
//               address. Contents come from the packed EXP_INIT vector,
//               entry i at bits [i*ALPHA_BW +: ALPHA_BW].
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_exp_rom #(
    parameter int SW_BW    = 4,
    parameter int ALPHA_BW = 8,
    parameter logic [(2**SW_BW)*ALPHA_BW-1:0] EXP_INIT = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SW_BW-1:0]    i_addr,
    output logic [ALPHA_BW-1:0] o_data
);

    localparam int c_depth = 2**SW_BW;

    logic [ALPHA_BW-1:0] w_mem [c_depth];
    logic [ALPHA_BW-1:0] r_data;

    for (genvar gi = 0; gi < c_depth; gi++) begin : g_entry
        assign w_mem[gi] = EXP_INIT[gi*ALPHA_BW +: ALPHA_BW];
    end

    // Registered table lookup
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else begin
            r_data <= w_mem[i_addr];
        end
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/cnn_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : cnn_sweep_checker
// Description : On-chip regression sequencer for cnn_top. Steps the image
//               select over a range, pulses o_valid for each image, waits
//               for the answer with a timeout, compares it with the
//               expected-character table and keeps saturating
//               pass/fail/timeout/spurious statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_sweep_checker
    import cnn_chk_pkg::*;
#(
    parameter int SW_BW        = 4,
    parameter int ALPHA_BW     = 8,
    parameter int CNT_BW       = 8,
    parameter int DRIVE_CYCLES = 10,
    parameter int TIMEOUT_CYC  = 200000,
    parameter int GAP_CYCLES   = 100,
    parameter logic [(2**SW_BW)*ALPHA_BW-1:0] EXP_INIT = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [SW_BW-1:0]    i_first_sw,
    input  logic [SW_BW:0]      i_num_tests,
    output logic [SW_BW-1:0]    o_sw,
    output logic                o_valid,
    input  logic                i_out_valid,
    input  logic [ALPHA_BW-1:0] i_alpha,
    output logic                o_busy,
    output logic                o_done,
    output logic [CNT_BW-1:0]   o_pass_cnt,
    output logic [CNT_BW-1:0]   o_fail_cnt,
    output logic [CNT_BW-1:0]   o_timeout_cnt,
    output logic [CNT_BW-1:0]   o_spur_cnt,
    output logic                o_mis_valid,
    output logic [SW_BW-1:0]    o_mis_sw,
    output logic [ALPHA_BW-1:0] o_mis_alpha,
    output logic [ALPHA_BW-1:0] o_mis_exp
);

    // One timer serves DRIVE, WAIT and GAP, so size it for the longest
    localparam int c_tmr_max = (TIMEOUT_CYC > GAP_CYCLES)
        ? ((TIMEOUT_CYC > DRIVE_CYCLES) ? TIMEOUT_CYC : DRIVE_CYCLES)
        : ((GAP_CYCLES  > DRIVE_CYCLES) ? GAP_CYCLES  : DRIVE_CYCLES);
    localparam int c_tmr_bw = $clog2(c_tmr_max + 1);
    localparam int c_k_bw   = SW_BW + 1;

    localparam logic [c_tmr_bw-1:0] c_drive_last = c_tmr_bw'(DRIVE_CYCLES - 1);
    localparam logic [c_tmr_bw-1:0] c_wait_last  = c_tmr_bw'(TIMEOUT_CYC - 1);
    localparam logic [c_tmr_bw-1:0] c_gap_last   = c_tmr_bw'(GAP_CYCLES - 1);
    localparam logic [31:0]         c_cnt_max    = 32'((2**CNT_BW) - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_tmr_bw-1:0] r_timer;
    logic                r_ov_prev;
    logic [SW_BW-1:0]    r_sw;
    logic [c_k_bw-1:0]   r_num;
    logic [c_k_bw-1:0]   r_k;
    logic [ALPHA_BW-1:0] r_alpha;
    logic [CNT_BW-1:0]   r_pass;
    logic [CNT_BW-1:0]   r_fail;
    logic [CNT_BW-1:0]   r_to;
    logic [CNT_BW-1:0]   r_spur;

    logic [ALPHA_BW-1:0] w_exp;
    logic [c_k_bw-1:0]   w_k_inc;
    logic                w_ov_rise;
    logic                w_in_resp;
    logic                w_resp;
    logic                w_spur;
    logic                w_check;
    logic                w_mis;
    logic                w_timed;
    logic                w_start_acc;
    logic                w_timeout;
    logic                w_gap_end;
    logic                w_last;
    logic [CNT_BW-1:0]   w_pass_inc;
    logic [CNT_BW-1:0]   w_fail_inc;
    logic [CNT_BW-1:0]   w_to_inc;
    logic [CNT_BW-1:0]   w_spur_inc;

    cnn_exp_rom #(
        .SW_BW    (SW_BW),
        .ALPHA_BW (ALPHA_BW),
        .EXP_INIT (EXP_INIT)
    ) u_exp_rom (
        .clk    (clk),
        .reset  (reset),
        .i_addr (r_sw),
        .o_data (w_exp)
    );

    // Only the rising edge of out_valid is an event; a held level is ignored
    assign w_ov_rise = i_out_valid & ~r_ov_prev;
    assign w_in_resp = (r_state == ST_DRIVE) || (r_state == ST_WAIT);
    assign w_resp    = w_ov_rise & w_in_resp;
    assign w_spur    = w_ov_rise & ~w_in_resp;
    assign w_check   = (r_state == ST_CHECK);
    assign w_mis     = w_check && (r_alpha != w_exp);
    assign w_timed   = (r_state == ST_DRIVE) || (r_state == ST_WAIT) || (r_state == ST_GAP);
    assign w_k_inc   = r_k + c_k_bw'(1);
    assign w_last    = (w_k_inc == r_num);

    assign w_pass_inc = CNT_BW'(sat_inc(32'(r_pass), c_cnt_max));
    assign w_fail_inc = CNT_BW'(sat_inc(32'(r_fail), c_cnt_max));
    assign w_to_inc   = CNT_BW'(sat_inc(32'(r_to),   c_cnt_max));
    assign w_spur_inc = CNT_BW'(sat_inc(32'(r_spur), c_cnt_max));

    // Next-state logic and per-state event strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_timeout   = 1'b0;
        w_gap_end   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = (i_num_tests == '0) ? ST_DONE : ST_LOAD;
                end else if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (w_ov_rise) begin
                    w_state_nxt = ST_CHECK;
                end else if (r_timer == c_drive_last) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_ov_rise) begin
                    w_state_nxt = ST_CHECK;
                end else if (r_timer == c_wait_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_CHECK: begin
                w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (r_timer == c_gap_last) begin
                    w_gap_end   = 1'b1;
                    w_state_nxt = w_last ? ST_DONE : ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and shared timer, which restarts on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_ov_prev <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ov_prev <= i_out_valid;
            if ((w_state_nxt != r_state) || !w_timed) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_tmr_bw'(1);
            end
        end
    end

    // Sweep bookkeeping: image index, remaining count and captured answer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw    <= '0;
            r_num   <= '0;
            r_k     <= '0;
            r_alpha <= '0;
        end else begin
            if (w_start_acc) begin
                r_num <= i_num_tests;
                r_k   <= '0;
                if (i_num_tests != '0) begin
                    r_sw <= i_first_sw;
                end
            end else if (w_gap_end) begin
                r_k <= w_k_inc;
                if (!w_last) begin
                    r_sw <= r_sw + SW_BW'(1);
                end
            end
            if (w_resp) begin
                r_alpha <= i_alpha;
            end
        end
    end

    // Saturating statistics, cleared at the start of every sweep
    always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
            r_pass <= '0;
            r_fail <= '0;
            r_to   <= '0;
            r_spur <= '0;
        end else begin
            if (w_check && !w_mis) begin
                r_pass <= w_pass_inc;
            end
            if (w_mis || w_timeout) begin
                r_fail <= w_fail_inc;
            end
            if (w_timeout) begin
                r_to <= w_to_inc;
            end
            if (w_spur) begin
                r_spur <= w_spur_inc;
            end
        end
    end

    assign o_sw          = r_sw;
    assign o_valid       = (r_state == ST_DRIVE);
    assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_done        = (r_state == ST_DONE);
    assign o_pass_cnt    = r_pass;
    assign o_fail_cnt    = r_fail;
    assign o_timeout_cnt = r_to;
    assign o_spur_cnt    = r_spur;
    assign o_mis_valid   = w_mis;
    assign o_mis_sw      = w_mis ? r_sw    : '0;
    assign o_mis_alpha   = w_mis ? r_alpha : '0;
    assign o_mis_exp     = w_mis ? w_exp   : '0;

endmodule
`default_nettype wire

// File: tb/tb_cnn_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_sweep_checker
// Description : Self-checking bench for cnn_sweep_checker with a behavioural
//               stand-in for cnn_top (per-image answer mode, latency and
//               pulse width). Expected table entry i is 'A'+i.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_sweep_checker;

    localparam int SW_BW        = 4;
    localparam int ALPHA_BW     = 8;
    localparam int CNT_BW       = 3;
    localparam int DRIVE_CYCLES = 10;
    localparam int TIMEOUT_CYC  = 1000;
    localparam int GAP_CYCLES   = 20;
    localparam int c_sat        = 7;
    localparam int c_limit      = 20000;

    // Answer modes of the cnn_top stand-in
    localparam int c_ok     = 0;
    localparam int c_wrong  = 1;
    localparam int c_silent = 2;

    function automatic logic [127:0] build_rom();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'h41 + 8'(i);
        return v;
    endfunction
    localparam logic [127:0] c_exp_init = build_rom();

    function automatic int exp_char(input int sw);
        return 'h41 + sw;
    endfunction

    function automatic int sat(input int v);
        return (v > c_sat) ? c_sat : v;
    endfunction

    // o_valid stays high until the answer is seen or DRIVE_CYCLES elapse
    function automatic int vh_expect(input int mode, input int delay);
        if (mode == c_silent) return DRIVE_CYCLES;
        return (delay + 1 < DRIVE_CYCLES) ? delay + 1 : DRIVE_CYCLES;
    endfunction

    logic                clk = 1'b0;
    logic                reset;
    logic                i_start;
    logic [SW_BW-1:0]    i_first_sw;
    logic [SW_BW:0]      i_num_tests;
    logic [SW_BW-1:0]    o_sw;
    logic                o_valid;
    logic                i_out_valid;
    logic [ALPHA_BW-1:0] i_alpha;
    logic                o_busy;
    logic                o_done;
    logic [CNT_BW-1:0]   o_pass_cnt;
    logic [CNT_BW-1:0]   o_fail_cnt;
    logic [CNT_BW-1:0]   o_timeout_cnt;
    logic [CNT_BW-1:0]   o_spur_cnt;
    logic                o_mis_valid;
    logic [SW_BW-1:0]    o_mis_sw;
    logic [ALPHA_BW-1:0] o_mis_alpha;
    logic [ALPHA_BW-1:0] o_mis_exp;

    logic                mdl_ov = 1'b0;
    logic                inj_ov = 1'b0;
    logic [ALPHA_BW-1:0] mdl_alpha = '0;
    assign i_out_valid = mdl_ov | inj_ov;
    assign i_alpha     = mdl_alpha;

    int mdl_mode [16];
    int mdl_delay[16];
    int mdl_width[16];

    typedef struct { int sw; int alpha; int exp; } mis_t;
    int   sw_q[$];
    int   vh_q[$];
    mis_t mis_q[$];
    int   done_cnt = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cnn_sweep_checker #(
        .SW_BW        (SW_BW),
        .ALPHA_BW     (ALPHA_BW),
        .CNT_BW       (CNT_BW),
        .DRIVE_CYCLES (DRIVE_CYCLES),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .GAP_CYCLES   (GAP_CYCLES),
        .EXP_INIT     (c_exp_init)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_first_sw    (i_first_sw),
        .i_num_tests   (i_num_tests),
        .o_sw          (o_sw),
        .o_valid       (o_valid),
        .i_out_valid   (i_out_valid),
        .i_alpha       (i_alpha),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_pass_cnt    (o_pass_cnt),
        .o_fail_cnt    (o_fail_cnt),
        .o_timeout_cnt (o_timeout_cnt),
        .o_spur_cnt    (o_spur_cnt),
        .o_mis_valid   (o_mis_valid),
        .o_mis_sw      (o_mis_sw),
        .o_mis_alpha   (o_mis_alpha),
        .o_mis_exp     (o_mis_exp)
    );

    // cnn_top stand-in: answers each o_valid rise per the per-image settings
    initial begin : cnn_model
        int sw;
        forever begin
            @(posedge o_valid);
            sw = int'(o_sw);
            sw_q.push_back(sw);
            @(negedge clk);
            if (mdl_mode[sw] != c_silent) begin
                repeat (mdl_delay[sw]) @(negedge clk);
                mdl_alpha = (mdl_mode[sw] == c_ok) ? 8'(exp_char(sw)) : 8'h58;
                mdl_ov    = 1'b1;
                repeat (mdl_width[sw]) @(negedge clk);
                mdl_ov    = 1'b0;
            end
        end
    end

    // Observers: o_valid run lengths, mismatch reports, done pulses
    initial begin : monitors
        int   run;
        mis_t m;
        run = 0;
        forever begin
            @(negedge clk);
            if (o_valid) run++;
            else if (run != 0) begin
                vh_q.push_back(run);
                run = 0;
            end
            if (o_mis_valid) begin
                m.sw = int'(o_mis_sw); m.alpha = int'(o_mis_alpha); m.exp = int'(o_mis_exp);
                mis_q.push_back(m);
            end
            if (o_done) done_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_model(input int delay, input int width);
        for (int s = 0; s < 16; s++) begin
            mdl_mode[s] = c_ok; mdl_delay[s] = delay; mdl_width[s] = width;
        end
    endtask

    task automatic start_sweep(input int first, input int num);
        @(negedge clk);
        i_first_sw  = 4'(first);
        i_num_tests = 5'(num);
        i_start     = 1'b1;
        @(negedge clk);
        i_start     = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!o_done && cycles < c_limit) begin
            @(negedge clk);
            cycles++;
        end
        check("done_seen", int'(o_done), 1);
    endtask

    task automatic wait_valid(input logic level);
        int n;
        n = 0;
        while (o_valid !== level && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("valid_wait", int'(o_valid), int'(level));
    endtask

    // Runs one sweep with the current model settings and checks everything
    task automatic run_check(input int first, input int num, input int e_pass,
                             input int e_fail, input int e_to, input int e_mis);
        int cyc, d0, sw;
        sw_q.delete(); vh_q.delete(); mis_q.delete();
        d0 = done_cnt;
        start_sweep(first, num);
        if (num > 0) check("busy_after_start", int'(o_busy), 1);
        wait_done(cyc);
        if (num == 0) check("zero_n_done_latency", cyc, 0);
        check("busy_at_done", int'(o_busy), 0);
        check("pass_cnt", int'(o_pass_cnt), e_pass);
        check("fail_cnt", int'(o_fail_cnt), e_fail);
        check("timeout_cnt", int'(o_timeout_cnt), e_to);
        check("spur_cnt", int'(o_spur_cnt), 0);
        @(negedge clk);
        check("done_pulse_width", int'(o_done), 0);
        check("done_count", done_cnt - d0, 1);
        check("sw_seq_len", sw_q.size(), num);
        check("valid_runs", vh_q.size(), num);
        for (int k = 0; k < num && k < sw_q.size(); k++) begin
            sw = (first + k) % 16;
            check("sw_seq", sw_q[k], sw);
            if (k < vh_q.size())
                check("valid_len", vh_q[k], vh_expect(mdl_mode[sw], mdl_delay[sw]));
        end
        check("mis_count", mis_q.size(), e_mis);
        foreach (mis_q[i]) begin
            check("mis_wrong_sw", mdl_mode[mis_q[i].sw], c_wrong);
            check("mis_alpha", mis_q[i].alpha, 'h58);
            check("mis_exp", mis_q[i].exp, exp_char(mis_q[i].sw));
        end
    endtask

    typedef struct {
        int first; int num; int wrong_sw; int silent_sw; int delay;
        int e_pass; int e_fail; int e_to; int e_mis;
    } vec_t;

    initial begin : main
        vec_t tbl[6];
        int   p, f, to, m, sil, first, num, r, sw;

        tbl[0] = '{4,  1,  -1, -1, 50, 1, 0, 0, 0};
        tbl[1] = '{14, 4,  -1, -1, 5,  4, 0, 0, 0};
        tbl[2] = '{0,  4,   2, -1, 12, 3, 1, 0, 1};
        tbl[3] = '{1,  4,  -1,  3, 3,  3, 1, 1, 0};
        tbl[4] = '{0,  16, -1, -1, 0,  7, 0, 0, 0};
        tbl[5] = '{9,  0,  -1, -1, 0,  0, 0, 0, 0};

        reset = 1'b1; i_start = 1'b0; i_first_sw = '0; i_num_tests = '0;
        set_model(0, 1);
        repeat (3) @(negedge clk);
        check("rst_valid", int'(o_valid), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_sw", int'(o_sw), 0);
        check("rst_pass", int'(o_pass_cnt), 0);
        check("rst_spur", int'(o_spur_cnt), 0);
        check("rst_mis", int'(o_mis_valid), 0);
        reset = 1'b0;

        // Directed table
        for (int t = 0; t < 6; t++) begin
            set_model(tbl[t].delay, 1);
            if (tbl[t].wrong_sw >= 0)  mdl_mode[tbl[t].wrong_sw]  = c_wrong;
            if (tbl[t].silent_sw >= 0) mdl_mode[tbl[t].silent_sw] = c_silent;
            run_check(tbl[t].first, tbl[t].num, tbl[t].e_pass, tbl[t].e_fail,
                      tbl[t].e_to, tbl[t].e_mis);
        end

        // Randomized sweeps against the per-image outcome model
        for (int it = 0; it < 6; it++) begin
            sil = 0;
            for (int s = 0; s < 16; s++) begin
                r = $urandom_range(0, 9);
                mdl_mode[s]  = (r < 7) ? c_ok : (r < 9 || sil >= 2) ? c_wrong : c_silent;
                if (mdl_mode[s] == c_silent) sil++;
                mdl_delay[s] = $urandom_range(0, 40);
                mdl_width[s] = $urandom_range(1, 3);
            end
            first = $urandom_range(0, 15);
            num   = $urandom_range(1, 16);
            p = 0; f = 0; to = 0; m = 0;
            for (int k = 0; k < num; k++) begin
                sw = (first + k) % 16;
                if (mdl_mode[sw] == c_ok) p++;
                else if (mdl_mode[sw] == c_wrong) begin f++; m++; end
                else begin f++; to++; end
            end
            run_check(first, num, sat(p), sat(f), sat(to), m);
        end

        // Spurious out_valid in GAP and in IDLE
        set_model(0, 1);
        start_sweep(7, 1);
        wait_valid(1'b1);
        repeat (8) @(negedge clk);
        inj_ov = 1'b1; @(negedge clk); inj_ov = 1'b0;
        wait_done(r);
        repeat (3) @(negedge clk);
        inj_ov = 1'b1; @(negedge clk); inj_ov = 1'b0;
        @(negedge clk);
        check("spur_gap_idle", int'(o_spur_cnt), 2);
        check("spur_pass", int'(o_pass_cnt), 1);
        check("spur_fail", int'(o_fail_cnt), 0);

        // Reset while waiting on the second image
        set_model(2, 1);
        mdl_mode[11] = c_silent;
        start_sweep(10, 2);
        wait_valid(1'b1);
        wait_valid(1'b0);
        wait_valid(1'b1);
        repeat (15) @(negedge clk);
        check("pre_reset_pass", int'(o_pass_cnt), 1);
        check("pre_reset_busy", int'(o_busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_valid", int'(o_valid), 0);
        check("abort_busy", int'(o_busy), 0);
        check("abort_pass", int'(o_pass_cnt), 0);
        check("abort_fail", int'(o_fail_cnt), 0);
        check("abort_sw", int'(o_sw), 0);
        reset = 1'b0;
        p = done_cnt;
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt - p, 0);
        check("abort_idle_busy", int'(o_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
